// File: rtl/rns_pkg.sv
// Shared definitions for the RNS mixed-radix converter: field widths,
// FSM encoding and the elaboration-time constant functions.
package rns_pkg;

  localparam int MOD_W   = 9;   // one packed modulus field
  localparam int RES_W   = 8;   // one residue field
  localparam int MAX_DOM = 4;   // largest supported domain count
  localparam int EXT_W   = MAX_DOM * MOD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_RECON = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Modular inverse of a mod m by the extended Euclidean algorithm.
  function automatic logic [RES_W-1:0] mod_inv(input int a, input int m);
    int t, new_t, r, new_r, q, tmp;
    t     = 0;
    new_t = 1;
    r     = m;
    new_r = a % m;
    while (new_r != 0) begin
      q     = r / new_r;
      tmp   = t - q * new_t;
      t     = new_t;
      new_t = tmp;
      tmp   = r - q * new_r;
      r     = new_r;
      new_r = tmp;
    end
    if (t < 0) t = t + m;
    return RES_W'(t);
  endfunction

  // Inverse table: entry (j, i) = m_j^-1 mod m_i for j < i, stored at
  // byte slot j*MAX_DOM + i. Unused slots are zero.
  function automatic logic [MAX_DOM*MAX_DOM*RES_W-1:0] inv_table(
    input int n, input logic [EXT_W-1:0] moduli);
    logic [MAX_DOM*MAX_DOM*RES_W-1:0] t;
    t = '0;
    for (int j = 0; j < n; j++)
      for (int i = j + 1; i < n; i++)
        t[(j * MAX_DOM + i) * RES_W +: RES_W] =
          mod_inv(int'(moduli[MOD_W * j +: MOD_W]), int'(moduli[MOD_W * i +: MOD_W]));
    return t;
  endfunction

  // Dynamic range M = product of the first n moduli.
  function automatic longint mod_product(input int n, input logic [EXT_W-1:0] moduli);
    longint p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * longint'(moduli[MOD_W * k +: MOD_W]);
    return p;
  endfunction

endpackage

// File: rtl/rns_mod_mulsub.sv
// Combinational modular step r = ((a - b) mod m) * c mod m, where m is
// the constant modulus of domain sel. a must already be reduced mod m;
// b may be any residue and is reduced here first.
module rns_mod_mulsub
  import rns_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter logic [MOD_W*NUM_DOMAINS-1:0] MODULI = {9'd129, 9'd256},
  parameter int IW = 1
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] c,
  input  logic [IW-1:0]    sel,
  output logic [RES_W-1:0] r
);

  logic [MOD_W-1:0]         m;
  logic [MOD_W-1:0]         b_red;
  logic [MOD_W-1:0]         diff;
  logic [RES_W+MOD_W-1:0]   prod;

  // Wrapping subtract then multiply by the inverse; product is at most 17 bits.
  always_comb begin
    m     = MODULI[MOD_W * int'(sel) +: MOD_W];
    b_red = {1'b0, b} % m;
    diff  = ({1'b0, a} >= b_red) ? ({1'b0, a} - b_red) : ({1'b0, a} + m - b_red);
    prod  = (RES_W+MOD_W)'(diff) * (RES_W+MOD_W)'(c);
    r     = RES_W'(prod % (RES_W+MOD_W)'(m));
  end

endmodule

// File: rtl/rns_mrc_converter.sv
// Sequential RNS-to-binary converter using mixed-radix conversion.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable while valid is high and ready low.
// in_ready is high only in IDLE; out_valid is high only in DONE.
module rns_mrc_converter
  import rns_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter logic [MOD_W*NUM_DOMAINS-1:0] MODULI = {9'd129, 9'd256},
  parameter int OUT_WID = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RES_W*NUM_DOMAINS-1:0] in_res,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WID-1:0]           out_data,
  output logic                         out_err,
  output logic                         busy,
  output state_t                       dbg_state
);

  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int AW = OUT_WID + 1;
  localparam int HW = OUT_WID + 10;
  localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULI);
  localparam logic [MAX_DOM*MAX_DOM*RES_W-1:0] INV_TAB = inv_table(NUM_DOMAINS, MOD_EXT);
  localparam longint M_TOTAL = mod_product(NUM_DOMAINS, MOD_EXT);
  localparam logic [HW-1:0] M_W    = HW'(M_TOTAL);
  localparam logic [HW-1:0] HALF_W = HW'((M_TOTAL + 1) / 2);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_DOMAINS - 1);
  localparam logic [IW-1:0] LAST_J = IW'((NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0);

  state_t            state, state_nxt;
  logic [RES_W-1:0]  d [NUM_DOMAINS];
  logic [IW-1:0]     j, i, k;
  logic              sgn;
  logic [AW-1:0]     acc;
  logic              any_bad;
  logic              last_pair;
  logic [RES_W-1:0]  inv_sel;
  logic [RES_W-1:0]  step;
  logic [HW-1:0]     horner;

  // Map an unsigned value into the centred range when signed output is requested.
  function automatic logic [OUT_WID-1:0] centre(input logic [HW-1:0] v, input logic s);
    return (s && v >= HALF_W) ? OUT_WID'(v - M_W) : OUT_WID'(v);
  endfunction

  assign dbg_state = state;
  assign last_pair = (i == LAST_I) && (j == LAST_J);
  assign inv_sel   = INV_TAB[(int'(j) * MAX_DOM + int'(i)) * RES_W +: RES_W];

  rns_mod_mulsub #(
    .NUM_DOMAINS(NUM_DOMAINS),
    .MODULI     (MODULI),
    .IW         (IW)
  ) u_step (
    .a  (d[i]),
    .b  (d[j]),
    .c  (inv_sel),
    .sel(i),
    .r  (step)
  );

  // Flag any offered residue that is not below its modulus.
  always_comb begin
    any_bad = 1'b0;
    for (int n = 0; n < NUM_DOMAINS; n++)
      if ({1'b0, in_res[RES_W * n +: RES_W]} >= MODULI[MOD_W * n +: MOD_W]) any_bad = 1'b1;
  end

  // One Horner step: acc * m_k + d_k.
  always_comb begin
    horner = HW'(acc) * HW'(MODULI[MOD_W * int'(k) +: MOD_W]) + HW'(d[k]);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (any_bad || NUM_DOMAINS == 1) ? ST_DONE : ST_DIGIT;
      end
      ST_DIGIT: begin
        busy = 1'b1;
        if (last_pair) state_nxt = ST_RECON;
      end
      ST_RECON: begin
        busy = 1'b1;
        if (k == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, mixed-radix digit steps, Horner reconstruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_DOMAINS; n++) d[n] <= '0;
      j        <= '0;
      i        <= '0;
      k        <= '0;
      sgn      <= 1'b0;
      acc      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int n = 0; n < NUM_DOMAINS; n++) d[n] <= in_res[RES_W * n +: RES_W];
            sgn     <= in_signed;
            j       <= '0;
            i       <= IW'(1);
            k       <= LAST_J;
            out_err <= any_bad;
            if (any_bad) out_data <= '0;
            else if (NUM_DOMAINS == 1) out_data <= centre(HW'(in_res[RES_W-1:0]), in_signed);
          end
        end
        ST_DIGIT: begin
          d[i] <= step;
          if (i == LAST_I) begin
            // The last digit written seeds the Horner accumulator.
            if (j == LAST_J) acc <= AW'(step);
            else begin
              j <= j + 1'b1;
              i <= IW'(int'(j) + 2);
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        ST_RECON: begin
          acc <= AW'(horner);
          if (k == '0) out_data <= centre(horner, sgn);
          else         k <= k - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_mrc_converter.sv
// Bench for rns_mrc_converter: default {129,256} instance and a three-domain
// {3,5,7} instance, table vectors, hand sequences and random sweeps.
module tb_rns_mrc_converter;
  import rns_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic        iv2, ir2, sg2, ov2, or2, err2, busy2;
  logic [15:0] res2, data2;
  state_t      st2;

  logic        iv3, ir3, sg3, ov3, or3, err3, busy3;
  logic [23:0] res3;
  logic [15:0] data3;
  state_t      st3;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [15:0] res;
    logic        sgn;
    logic [15:0] data;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  rns_mrc_converter dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_res(res2),
    .in_signed(sg2), .out_valid(ov2), .out_ready(or2), .out_data(data2),
    .out_err(err2), .busy(busy2), .dbg_state(st2)
  );

  rns_mrc_converter #(
    .NUM_DOMAINS(3),
    .MODULI({9'd7, 9'd5, 9'd3}),
    .OUT_WID(16)
  ) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .in_res(res3),
    .in_signed(sg3), .out_valid(ov3), .out_ready(or3), .out_data(data3),
    .out_err(err3), .busy(busy3), .dbg_state(st3)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: residues of an integer and its expected output value.
  function automatic logic [23:0] residues(input int v, input int which);
    logic [23:0] r;
    r = '0;
    if (which == 2) begin
      r[7:0]  = 8'(v % 256);
      r[15:8] = 8'(v % 129);
    end else begin
      r[7:0]   = 8'(v % 3);
      r[15:8]  = 8'(v % 5);
      r[23:16] = 8'(v % 7);
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_value(input int v, input int m_total, input logic sgn);
    return (sgn && v >= (m_total + 1) / 2) ? 16'(v - m_total) : 16'(v);
  endfunction

  // Driver: offer one vector, wait (bounded) for the result, then accept it.
  // lat counts rising edges after the accept edge until out_valid is seen.
  task automatic conv(input int which, input logic [23:0] res, input logic sgn,
                      output logic [15:0] data, output logic err, output int lat);
    @(negedge clk);
    if (which == 2) begin res2 = res[15:0]; sg2 = sgn; iv2 = 1'b1; end
    else            begin res3 = res;       sg3 = sgn; iv3 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    iv3 = 1'b0;
    lat = 0;
    while (!((which == 2) ? ov2 : ov3) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    data = (which == 2) ? data2 : data3;
    err  = (which == 2) ? err2 : err3;
    or2 = 1'b1;
    or3 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    or3 = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    int          lat;
    int          v;
    logic        s;
    logic [23:0] r;
    logic [16:0] exp;

    vecs[0] = '{16'h61E8, 1'b0, 16'd1000,  1'b0, 2};
    vecs[1] = '{16'h80FF, 1'b0, 16'd33023, 1'b0, 2};
    vecs[2] = '{16'h80FF, 1'b1, 16'hFFFF,  1'b0, 2};
    vecs[3] = '{16'h8205, 1'b0, 16'h0000,  1'b1, 0};
    vecs[4] = '{16'h0080, 1'b1, 16'hBF80,  1'b0, 2};
    vecs[5] = '{16'h807F, 1'b1, 16'h407F,  1'b0, 2};
    vecs[6] = '{16'h8100, 1'b1, 16'h0000,  1'b1, 0};
    vecs[7] = '{16'h0101, 1'b1, 16'h0001,  1'b0, 2};

    reset = 1'b1;
    iv2 = 1'b0; sg2 = 1'b0; or2 = 1'b0; res2 = '0;
    iv3 = 1'b0; sg3 = 1'b0; or3 = 1'b0; res3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst in_ready", 32'(ir2), 32'd1);
    check("rst out_valid", 32'(ov2), 32'd0);
    check("rst out_data", 32'(data2), 32'd0);
    check("rst out_err", 32'(err2), 32'd0);
    check("rst busy", 32'(busy2), 32'd0);
    check("rst state", 32'(st2), 32'(ST_IDLE));

    // Table-driven vectors on the default instance.
    for (int n = 0; n < 8; n++) begin
      conv(2, {8'h00, vecs[n].res}, vecs[n].sgn, d, e, lat);
      check($sformatf("vec%0d data", n), 32'(d), 32'(vecs[n].data));
      check($sformatf("vec%0d err", n), 32'(e), 32'(vecs[n].err));
      check($sformatf("vec%0d latency", n), 32'(lat), 32'(vecs[n].lat));
    end

    // Backpressure on the 1000 result; in_valid pulses during DONE are ignored.
    @(negedge clk);
    res2 = 16'h61E8; sg2 = 1'b0; iv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    check("bp busy", 32'(busy2), 32'd1);
    check("bp in_ready busy", 32'(ir2), 32'd0);
    @(negedge clk);
    check("bp digit d1", 32'(dut2.d[1]), 32'd3);
    @(negedge clk);
    check("bp out_valid", 32'(ov2), 32'd1);
    for (int c = 0; c < 5; c++) begin
      iv2 = 1'b1;
      res2 = 16'($urandom);
      @(negedge clk);
      check("bp hold data", 32'(data2), 32'd1000);
      check("bp hold in_ready", 32'(ir2), 32'd0);
      check("bp hold valid", 32'(ov2), 32'd1);
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    check("bp release valid", 32'(ov2), 32'd0);
    check("bp release in_ready", 32'(ir2), 32'd1);
    check("bp release data", 32'(data2), 32'd1000);
    check("bp release state", 32'(st2), 32'(ST_IDLE));

    // Asynchronous reset one cycle after accept aborts the conversion.
    @(negedge clk);
    res2 = 16'h61E8; sg2 = 1'b0; iv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst in_ready", 32'(ir2), 32'd1);
    check("arst out_valid", 32'(ov2), 32'd0);
    check("arst busy", 32'(busy2), 32'd0);
    check("arst out_data", 32'(data2), 32'd0);
    check("arst out_err", 32'(err2), 32'd0);
    check("arst state", 32'(st2), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    conv(2, 24'h0, 1'b0, d, e, lat);
    check("post-reset zero data", 32'(d), 32'd0);
    check("post-reset zero err", 32'(e), 32'd0);
    check("post-reset latency", 32'(lat), 32'd2);

    // Three-domain instance: value 52 with a five-edge latency.
    conv(3, 24'h030201, 1'b0, d, e, lat);
    check("n3 value52", 32'(d), 32'd52);
    check("n3 latency", 32'(lat), 32'd5);

    // Random sweep on the three-domain instance.
    for (int n = 0; n < 30; n++) begin
      v = int'($urandom_range(0, 104));
      s = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, ref_value(v, 105, s)});
      conv(3, residues(v, 3), s, d, e, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand3 v=%0d s=%0d", v, s), 32'({e, d}), 32'(exp));
    end

    // Random sweep on the default instance, with occasional out-of-range residues.
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(0, 33023));
      s = 1'($urandom_range(0, 1));
      r = residues(v, 2);
      if ($urandom_range(0, 7) == 0) begin
        r[15:8] = 8'($urandom_range(129, 255));
        exp_q.push_back({1'b1, 16'h0000});
      end else begin
        exp_q.push_back({1'b0, ref_value(v, 33024, s)});
      end
      conv(2, r, s, d, e, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand2 res=%0h s=%0d", r[15:0], s), 32'({e, d}), 32'(exp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
